// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: bypass, user DR with update latch, optional IDCODE.
// Define JTAG_DR_BANK_IDCODE_EN to build the IDCODE register and SEL=10 decode.
module jtag_dr_bank #(
    parameter int          DR_W       = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            TCK,
    input  logic            RST,
    input  logic            TDI,
    input  logic            CAPTURE,
    input  logic            SHIFT,
    input  logic            UPDATE,
    input  logic [1:0]      SEL,
    input  logic [DR_W-1:0] PI,
    output logic [DR_W-1:0] PO,
    output logic            TDO,
    output logic [7:0]      SHIFT_CNT
);

    if (DR_W < 2 || DR_W > 64) begin : g_bad_width
        $error("jtag_dr_bank: DR_W out of range");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_dr_bank: IDCODE_VAL bit 0 must be 1");
    end

    logic            r_bypass;
    logic [DR_W-1:0] r_user;
    logic [DR_W-1:0] r_po;
    logic [7:0]      r_cnt;

    logic w_sel_user;
    logic w_sel_id;
    logic w_sel_byp;
    logic w_tdo;

    assign w_sel_user = (SEL == 2'b01);
`ifdef JTAG_DR_BANK_IDCODE_EN
    assign w_sel_id   = (SEL == 2'b10);
`else
    assign w_sel_id   = 1'b0;
`endif
    assign w_sel_byp  = !w_sel_user && !w_sel_id;

`ifdef JTAG_DR_BANK_IDCODE_EN
    logic [31:0] r_idcode;

    always_ff @(posedge TCK or posedge RST) begin
        if (RST) begin
            r_idcode <= IDCODE_VAL;
        end else if (CAPTURE) begin
            if (w_sel_id) r_idcode <= IDCODE_VAL;
        end else if (SHIFT) begin
            if (w_sel_id) r_idcode <= {TDI, r_idcode[31:1]};
        end
    end
`endif

    // Strobe priority: CAPTURE, then SHIFT, then UPDATE.
    always_ff @(posedge TCK or posedge RST) begin
        if (RST) begin
            r_bypass <= 1'b0;
            r_user   <= '0;
            r_po     <= '0;
            r_cnt    <= 8'd0;
        end else if (CAPTURE) begin
            r_cnt <= 8'd0;
            if (w_sel_byp)  r_bypass <= 1'b0;
            if (w_sel_user) r_user   <= PI;
        end else if (SHIFT) begin
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            if (w_sel_byp)  r_bypass <= TDI;
            if (w_sel_user) r_user   <= {TDI, r_user[DR_W-1:1]};
        end else if (UPDATE) begin
            if (w_sel_user) r_po <= r_user;
        end
    end

    always_comb begin
        w_tdo = r_bypass;
        unique case (1'b1)
            w_sel_user: w_tdo = r_user[0];
`ifdef JTAG_DR_BANK_IDCODE_EN
            w_sel_id:   w_tdo = r_idcode[0];
`endif
            default:    w_tdo = r_bypass;
        endcase
    end

    assign TDO       = w_tdo;
    assign PO        = r_po;
    assign SHIFT_CNT = r_cnt;

endmodule
